// File: rtl/bp_io_cmd_router_if.sv
// Command/response bundle between IO command sources, the router and the IO NoC.
// slave: router side. master: the side that drives commands and returns responses.
interface bp_io_cmd_router_if #(
   parameter int num_ch_p     = 2,
   parameter int cmd_width_p  = 128,
   parameter int resp_width_p = 128,
   parameter int did_width_p  = 3
);
   localparam int cid_w = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;

   logic [num_ch_p*cmd_width_p-1:0] cmd_i;
   logic [num_ch_p-1:0]             cmd_v_i;
   logic [num_ch_p-1:0]             cmd_yumi_o;
   logic [cmd_width_p-1:0]          cmd_o;
   logic [did_width_p-1:0]          cmd_dst_did_o;
   logic [cid_w-1:0]                cmd_cid_o;
   logic                            cmd_v_o;
   logic                            cmd_ready_i;
   logic [resp_width_p-1:0]         resp_i;
   logic [cid_w-1:0]                resp_cid_i;
   logic                            resp_v_i;
   logic                            resp_yumi_o;
   logic [resp_width_p-1:0]         resp_o;
   logic [num_ch_p-1:0]             resp_v_o;
   logic [num_ch_p-1:0]             resp_ready_i;

   modport slave (
      input  cmd_i, cmd_v_i, cmd_ready_i, resp_i, resp_cid_i, resp_v_i, resp_ready_i,
      output cmd_yumi_o, cmd_o, cmd_dst_did_o, cmd_cid_o, cmd_v_o, resp_yumi_o, resp_o, resp_v_o
   );

   modport master (
      output cmd_i, cmd_v_i, cmd_ready_i, resp_i, resp_cid_i, resp_v_i, resp_ready_i,
      input  cmd_yumi_o, cmd_o, cmd_dst_did_o, cmd_cid_o, cmd_v_o, resp_yumi_o, resp_o, resp_v_o
   );
endinterface

// File: rtl/bp_io_cmd_router.sv
// bp_io_cmd_router: round-robin arbitration of num_ch_p IO command sources onto one IO NoC
// command port, destination-DID decode, per-channel credit tracking and response steering.
// Optional macro BP_IO_CMD_ROUTER_ERR_RESP_EN: swallow bad responses and raise sticky err_o.
module bp_io_cmd_router #(
   parameter int num_ch_p       = 2,
   parameter int cmd_width_p    = 128,
   parameter int resp_width_p   = 128,
   parameter int paddr_width_p  = 40,
   parameter int did_width_p    = 3,
   parameter int did_offset_p   = 37,
   parameter int dev_offset_p   = 16,
   parameter int dev_width_p    = 4,
   parameter logic [(2**dev_width_p)-1:0] host_dev_mask_p = 16'h0007,
   parameter int max_credits_p  = 8
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [did_width_p-1:0] my_did_i,
   input  logic [did_width_p-1:0] host_did_i,
   bp_io_cmd_router_if.slave      io,
   output logic                   err_o
);
   localparam int cid_w = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
   localparam int crd_w = $clog2(max_credits_p + 1);
   localparam logic [crd_w-1:0] max_crd = crd_w'(max_credits_p);

   // Channel index base+off wrapped into 0..num_ch_p-1.
   function automatic logic [cid_w-1:0] rr_idx(input logic [cid_w-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= num_ch_p) s = s - num_ch_p;
      return cid_w'(s);
   endfunction

   // Non-zero global DID wins; otherwise the local device field picks host or this tile.
   function automatic logic [did_width_p-1:0] decode_did(
      input logic [did_width_p-1:0] gdid, input logic [dev_width_p-1:0] dev,
      input logic [did_width_p-1:0] my_did, input logic [did_width_p-1:0] host_did);
      if (gdid != '0) return gdid;
      if (host_dev_mask_p[dev]) return host_did;
      return my_did;
   endfunction

   logic                   out_v_q, out_v_d;
   logic [cmd_width_p-1:0] out_cmd_q;
   logic [did_width_p-1:0] out_did_q;
   logic [cid_w-1:0]       out_cid_q;
   logic [cid_w-1:0]       ptr_q, ptr_d;
   logic [crd_w-1:0]       credit_q [num_ch_p];
   logic [crd_w-1:0]       credit_d [num_ch_p];

   logic [num_ch_p-1:0]    eligible;
   logic [num_ch_p-1:0]    cmd_yumi;
   logic                   win_found, take;
   logic [cid_w-1:0]       win_idx;
   logic [cmd_width_p-1:0] sel_cmd;
   logic [num_ch_p-1:0]    resp_hit, resp_v;
   logic                   resp_ready_sel, bad_resp;

   // Round-robin pick among channels holding a command and a free credit.
   always_comb begin
      eligible  = '0;
      win_found = 1'b0;
      win_idx   = '0;
      cmd_yumi  = '0;
      sel_cmd   = '0;
      for (int c = 0; c < num_ch_p; c++) eligible[c] = io.cmd_v_i[c] & (credit_q[c] < max_crd);
      for (int i = 0; i < num_ch_p; i++) begin
         if (!win_found && eligible[rr_idx(ptr_q, i)]) begin
            win_found = 1'b1;
            win_idx   = rr_idx(ptr_q, i);
         end
      end
      // Output slot is free when empty or being drained this same cycle.
      take = ~reset_i & win_found & (~out_v_q | io.cmd_ready_i);
      for (int c = 0; c < num_ch_p; c++) begin
         cmd_yumi[c] = take & (win_idx == cid_w'(c));
         if (win_idx == cid_w'(c)) sel_cmd = io.cmd_i[c*cmd_width_p +: cmd_width_p];
      end
      out_v_d = take ? 1'b1 : (io.cmd_ready_i ? 1'b0 : out_v_q);
      ptr_d   = take ? rr_idx(win_idx, 1) : ptr_q;
   end

   // Response steering by cid; bad responses are recognised only when error handling is built.
   always_comb begin
      resp_hit       = '0;
      resp_ready_sel = 1'b0;
      bad_resp       = 1'b0;
      for (int c = 0; c < num_ch_p; c++) begin
         if (io.resp_cid_i == cid_w'(c)) begin
            resp_hit[c]    = 1'b1;
            resp_ready_sel = io.resp_ready_i[c];
`ifdef BP_IO_CMD_ROUTER_ERR_RESP_EN
            bad_resp       = io.resp_v_i & (credit_q[c] == '0);
`endif
         end
      end
`ifdef BP_IO_CMD_ROUTER_ERR_RESP_EN
      if (io.resp_v_i && (resp_hit == '0)) bad_resp = 1'b1;
`endif
      resp_v = (reset_i | bad_resp) ? '0 : ({num_ch_p{io.resp_v_i}} & resp_hit);
   end

   // Credit next state: +1 on issue, -1 on returned response, both cancel out.
   always_comb begin
      credit_d = credit_q;
      for (int c = 0; c < num_ch_p; c++) begin
         if (cmd_yumi[c] && !(resp_v[c] && io.resp_ready_i[c]))
            credit_d[c] = credit_q[c] + crd_w'(1);
         else if (!cmd_yumi[c] && resp_v[c] && io.resp_ready_i[c] && (credit_q[c] != '0))
            credit_d[c] = credit_q[c] - crd_w'(1);
      end
   end

   // Control state: output-valid, RR pointer and credits.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         out_v_q <= 1'b0;
         ptr_q   <= '0;
         for (int c = 0; c < num_ch_p; c++) credit_q[c] <= '0;
      end else begin
         out_v_q  <= out_v_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
      end
   end

   // Output data slot, loaded with the winner's command and its decoded DID.
   always_ff @(posedge clk_i) begin
      if (take) begin
         out_cmd_q <= sel_cmd;
         out_did_q <= decode_did(sel_cmd[did_offset_p +: did_width_p],
                                 sel_cmd[dev_offset_p +: dev_width_p], my_did_i, host_did_i);
         out_cid_q <= win_idx;
      end
   end

`ifdef BP_IO_CMD_ROUTER_ERR_RESP_EN
   logic err_q;
   // Sticky protocol error, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) err_q <= 1'b0;
      else         err_q <= err_q | bad_resp;
   end
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign io.cmd_yumi_o    = cmd_yumi;
   assign io.cmd_o         = out_cmd_q;
   assign io.cmd_dst_did_o = out_did_q;
   assign io.cmd_cid_o     = out_cid_q;
   assign io.cmd_v_o       = out_v_q;
   assign io.resp_o        = io.resp_i;
   assign io.resp_v_o      = resp_v;
   assign io.resp_yumi_o   = ~reset_i & io.resp_v_i & (resp_ready_sel | bad_resp);
endmodule

// File: tb/tb_bp_io_cmd_router.sv
// Self-checking bench for bp_io_cmd_router with a transaction-level reference model.
module tb_bp_io_cmd_router;
   localparam int N = 2, CW = 128, RW = 128, PW = 40, DW = 3;
   localparam int DIDO = 37, DEVO = 16, MAXC = 8;
   localparam logic [15:0] MASK = 16'h0007;

   logic clk = 1'b0;
   logic rst;
   logic [DW-1:0] my_did   = 3'd5;
   logic [DW-1:0] host_did = 3'd6;
   logic err;

   always #5 clk = ~clk;

   bp_io_cmd_router_if #(.num_ch_p(N), .cmd_width_p(CW), .resp_width_p(RW), .did_width_p(DW)) bus ();

   bp_io_cmd_router #(.num_ch_p(N), .cmd_width_p(CW), .resp_width_p(RW), .paddr_width_p(PW),
      .did_width_p(DW), .did_offset_p(DIDO), .dev_offset_p(DEVO), .dev_width_p(4),
      .host_dev_mask_p(MASK), .max_credits_p(MAXC)) dut (
      .clk_i(clk), .reset_i(rst), .my_did_i(my_did), .host_did_i(host_did),
      .io(bus), .err_o(err));

   int n_cmp = 0, n_fail = 0;

   // Reference model: outstanding count per channel, next-preferred channel, output slot.
   int m_crd [N];
   int m_ptr;
   bit m_ov;
   logic [CW-1:0] m_cmd;
   logic [DW-1:0] m_did;
   int m_cid;
   bit m_err;

   function automatic logic [DW-1:0] exp_did(input logic [CW-1:0] c);
      logic [PW-1:0] a;
      logic [15:0] mk;
      int g, d;
      a = c[PW-1:0];
      mk = MASK;
      g = int'((a >> DIDO) & 40'd7);
      d = int'((a >> DEVO) & 40'd15);
      if (g != 0) return DW'(g);
      if (mk[d]) return host_did;
      return my_did;
   endfunction

   function automatic logic [CW-1:0] rand_cmd(input int g, input int dev);
      logic [CW-1:0] c;
      c = {$urandom, $urandom, $urandom, $urandom};
      c[39:37] = 3'(g);
      c[19:16] = 4'(dev);
      return c;
   endfunction

   function automatic int m_win();
      if (rst) return -1;
      if (m_ov && !bus.cmd_ready_i) return -1;
      for (int i = 0; i < N; i++) begin
         int c;
         c = (m_ptr + i) % N;
         if (bus.cmd_v_i[c] && m_crd[c] < MAXC) return c;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] m_yumi();
      logic [N-1:0] r;
      int w;
      r = '0;
      w = m_win();
      if (w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   function automatic bit m_bad();
      int c;
      c = int'(bus.resp_cid_i);
      return bus.resp_v_i && (c >= N || m_crd[c] == 0);
   endfunction

   function automatic logic [N-1:0] m_resp_v();
      logic [N-1:0] r;
      r = '0;
      if (rst || !bus.resp_v_i) return r;
`ifdef BP_IO_CMD_ROUTER_ERR_RESP_EN
      if (m_bad()) return r;
`endif
      r[int'(bus.resp_cid_i)] = 1'b1;
      return r;
   endfunction

   function automatic logic m_resp_yumi();
      if (rst || !bus.resp_v_i) return 1'b0;
`ifdef BP_IO_CMD_ROUTER_ERR_RESP_EN
      if (m_bad()) return 1'b1;
`endif
      return bus.resp_ready_i[int'(bus.resp_cid_i)];
   endfunction

   // Advance one clock and apply the model's view of what that edge did.
   task automatic tick();
      int w, rc;
      logic [N-1:0] rv;
      @(posedge clk);
      if (rst) begin
         m_ov = 0; m_ptr = 0; m_err = 0;
         for (int c = 0; c < N; c++) m_crd[c] = 0;
      end else begin
         w  = m_win();
         rv = m_resp_v();
         rc = int'(bus.resp_cid_i);
`ifdef BP_IO_CMD_ROUTER_ERR_RESP_EN
         if (m_bad()) m_err = 1;
`endif
         if (rv != '0 && bus.resp_ready_i[rc]) m_crd[rc] = m_crd[rc] - 1;
         if (w >= 0) begin
            m_ov = 1; m_cmd = bus.cmd_i[w*CW +: CW]; m_did = exp_did(m_cmd);
            m_cid = w; m_ptr = (w + 1) % N; m_crd[w] = m_crd[w] + 1;
         end else if (bus.cmd_ready_i) m_ov = 0;
      end
      #1;
   endtask

   task automatic clear_inputs();
      bus.cmd_i = '0; bus.cmd_v_i = '0; bus.cmd_ready_i = 1'b0;
      bus.resp_i = '0; bus.resp_cid_i = '0; bus.resp_v_i = 1'b0; bus.resp_ready_i = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.cmd_i = {rand_cmd(0, 1), rand_cmd(2, 3)}; bus.cmd_v_i = 2'b11; bus.cmd_ready_i = 1'b1;
      bus.resp_v_i = 1'b1; bus.resp_cid_i = 1'b0; bus.resp_ready_i = 2'b11;
      #1;
      n_cmp++; if (bus.cmd_yumi_o !== 2'b00) begin n_fail++; $display("FAIL rst_yumi got %b exp 00", bus.cmd_yumi_o); end
      n_cmp++; if (bus.resp_v_o !== 2'b00) begin n_fail++; $display("FAIL rst_resp_v got %b exp 00", bus.resp_v_o); end
      n_cmp++; if (bus.resp_yumi_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp_yumi got %b exp 0", bus.resp_yumi_o); end
      tick(); tick();
      n_cmp++; if (bus.cmd_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_v got %b exp 0", bus.cmd_v_o); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err); end
      rst = 1'b0;
      clear_inputs();
      tick();
      n_cmp++; if (bus.cmd_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle_cmd_v got %b exp 0", bus.cmd_v_o); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] alt;
      do_reset();
      bus.cmd_v_i = 2'b11; bus.cmd_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.cmd_i = {rand_cmd(0, 5), rand_cmd(1, 0)};
         #1;
         alt = (i % 2 == 0) ? 2'b01 : 2'b10;
         n_cmp++; if (bus.cmd_yumi_o !== alt) begin n_fail++; $display("FAIL rr_yumi cyc%0d got %b exp %b", i, bus.cmd_yumi_o, alt); end
         tick();
         n_cmp++; if (bus.cmd_v_o !== 1'b1 || bus.cmd_cid_o !== 1'(i % 2) || bus.cmd_o !== m_cmd) begin
            n_fail++; $display("FAIL rr_out cyc%0d got v%b cid%0d exp v1 cid%0d", i, bus.cmd_v_o, bus.cmd_cid_o, i % 2); end
      end
   endtask

   task automatic test_did_decode();
      int g_tbl [7] = '{0, 0, 3, 3, 0, 0, 0};
      int d_tbl [7] = '{1, 5, 9, 1, 0, 2, 3};
      logic [DW-1:0] e_tbl [7] = '{3'd6, 3'd5, 3'd3, 3'd3, 3'd6, 3'd6, 3'd5};
      do_reset();
      bus.cmd_ready_i = 1'b1;
      for (int i = 0; i < 7; i++) begin
         bus.cmd_v_i = 2'b01;
         bus.cmd_i = {rand_cmd(7, 7), rand_cmd(g_tbl[i], d_tbl[i])};
         #1;
         tick();
         n_cmp++; if (bus.cmd_dst_did_o !== e_tbl[i] || bus.cmd_dst_did_o !== m_did) begin
            n_fail++; $display("FAIL did_decode case%0d got %0d exp %0d", i, bus.cmd_dst_did_o, e_tbl[i]); end
      end
   endtask

   task automatic test_credit_block();
      do_reset();
      bus.cmd_v_i = 2'b01; bus.cmd_ready_i = 1'b1;
      for (int i = 0; i < MAXC; i++) begin
         bus.cmd_i = {rand_cmd(0, 0), rand_cmd(0, 4)};
         #1;
         n_cmp++; if (bus.cmd_yumi_o !== 2'b01) begin n_fail++; $display("FAIL crd_issue n%0d got %b exp 01", i, bus.cmd_yumi_o); end
         tick();
      end
      #1;
      n_cmp++; if (bus.cmd_yumi_o !== 2'b00) begin n_fail++; $display("FAIL crd_block got %b exp 00", bus.cmd_yumi_o); end
      tick();
      bus.resp_v_i = 1'b1; bus.resp_cid_i = 1'b0; bus.resp_ready_i = 2'b01; bus.resp_i = {4{$urandom}};
      #1;
      n_cmp++; if (bus.cmd_yumi_o !== 2'b00) begin n_fail++; $display("FAIL crd_block_resp got %b exp 00", bus.cmd_yumi_o); end
      n_cmp++; if (bus.resp_v_o !== 2'b01 || bus.resp_yumi_o !== 1'b1) begin
         n_fail++; $display("FAIL crd_resp got v%b yumi%b exp v01 yumi1", bus.resp_v_o, bus.resp_yumi_o); end
      tick();
      bus.resp_v_i = 1'b0;
      #1;
      n_cmp++; if (bus.cmd_yumi_o !== 2'b01) begin n_fail++; $display("FAIL crd_unblock got %b exp 01", bus.cmd_yumi_o); end
      tick();
   endtask

   task automatic test_stall();
      do_reset();
      bus.cmd_v_i = 2'b11; bus.cmd_ready_i = 1'b1;
      bus.cmd_i = {rand_cmd(2, 2), rand_cmd(0, 1)};
      #1;
      tick();
      bus.cmd_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.cmd_i = {rand_cmd(1, 1), rand_cmd(4, 4)};
         #1;
         n_cmp++; if (bus.cmd_yumi_o !== 2'b00) begin n_fail++; $display("FAIL stall_yumi cyc%0d got %b exp 00", i, bus.cmd_yumi_o); end
         tick();
         n_cmp++; if (bus.cmd_v_o !== 1'b1 || bus.cmd_o !== m_cmd || bus.cmd_cid_o !== 1'b0 || bus.cmd_dst_did_o !== 3'd6) begin
            n_fail++; $display("FAIL stall_hold cyc%0d got v%b cid%0d did%0d exp v1 cid0 did6", i, bus.cmd_v_o, bus.cmd_cid_o, bus.cmd_dst_did_o); end
      end
      bus.cmd_ready_i = 1'b1;
      #1;
      n_cmp++; if (bus.cmd_yumi_o !== 2'b10) begin n_fail++; $display("FAIL stall_release got %b exp 10", bus.cmd_yumi_o); end
      tick();
      n_cmp++; if (bus.cmd_v_o !== 1'b1 || bus.cmd_cid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_1 got v%b cid%0d exp v1 cid1", bus.cmd_v_o, bus.cmd_cid_o); end
      #1;
      n_cmp++; if (bus.cmd_yumi_o !== 2'b01) begin n_fail++; $display("FAIL b2b_yumi got %b exp 01", bus.cmd_yumi_o); end
      tick();
      n_cmp++; if (bus.cmd_v_o !== 1'b1 || bus.cmd_cid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_2 got v%b cid%0d exp v1 cid0", bus.cmd_v_o, bus.cmd_cid_o); end
   endtask

   task automatic test_same_cycle_credit();
      do_reset();
      bus.cmd_v_i = 2'b10; bus.cmd_ready_i = 1'b1;
      bus.cmd_i = {rand_cmd(0, 6), rand_cmd(0, 6)};
      #1;
      tick();
      bus.resp_v_i = 1'b1; bus.resp_cid_i = 1'b1; bus.resp_ready_i = 2'b10;
      #1;
      n_cmp++; if (bus.cmd_yumi_o !== 2'b10 || bus.resp_v_o !== 2'b10 || bus.resp_yumi_o !== 1'b1) begin
         n_fail++; $display("FAIL same_cyc got yumi%b rv%b ry%b exp yumi10 rv10 ry1", bus.cmd_yumi_o, bus.resp_v_o, bus.resp_yumi_o); end
      tick();
      bus.resp_v_i = 1'b0;
      for (int i = 0; i < MAXC - 1; i++) begin
         #1;
         n_cmp++; if (bus.cmd_yumi_o !== 2'b10) begin n_fail++; $display("FAIL same_cyc_fill n%0d got %b exp 10", i, bus.cmd_yumi_o); end
         tick();
      end
      #1;
      n_cmp++; if (bus.cmd_yumi_o !== 2'b00) begin n_fail++; $display("FAIL same_cyc_full got %b exp 00", bus.cmd_yumi_o); end
      tick();
   endtask

   task automatic test_random();
      int c;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         bus.cmd_v_i = 2'($urandom_range(0, 3));
         bus.cmd_i = {rand_cmd(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7), $urandom_range(0, 15)),
                      rand_cmd(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7), $urandom_range(0, 15))};
         bus.cmd_ready_i = ($urandom_range(0, 3) != 0);
         c = $urandom_range(0, N - 1);
         bus.resp_cid_i = 1'(c);
         bus.resp_v_i = (m_crd[c] > 0) && ($urandom_range(0, 1) == 1);
         bus.resp_ready_i = 2'($urandom_range(0, 3));
         bus.resp_i = {$urandom, $urandom, $urandom, $urandom};
         #1;
         n_cmp++; if (bus.cmd_yumi_o !== m_yumi()) begin n_fail++; $display("FAIL rnd_yumi cyc%0d got %b exp %b", i, bus.cmd_yumi_o, m_yumi()); end
         n_cmp++; if (bus.resp_v_o !== m_resp_v() || bus.resp_yumi_o !== m_resp_yumi() || bus.resp_o !== bus.resp_i) begin
            n_fail++; $display("FAIL rnd_resp cyc%0d got v%b y%b exp v%b y%b", i, bus.resp_v_o, bus.resp_yumi_o, m_resp_v(), m_resp_yumi()); end
         tick();
         n_cmp++; if (bus.cmd_v_o !== m_ov) begin n_fail++; $display("FAIL rnd_cmd_v cyc%0d got %b exp %b", i, bus.cmd_v_o, m_ov); end
         if (m_ov) begin
            n_cmp++; if (bus.cmd_o !== m_cmd || bus.cmd_dst_did_o !== m_did || bus.cmd_cid_o !== 1'(m_cid)) begin
               n_fail++; $display("FAIL rnd_cmd cyc%0d got did%0d cid%0d exp did%0d cid%0d", i, bus.cmd_dst_did_o, bus.cmd_cid_o, m_did, m_cid); end
         end
      end
      rst = 1'b0;
      clear_inputs();
   endtask

`ifdef BP_IO_CMD_ROUTER_ERR_RESP_EN
   task automatic test_err_resp();
      do_reset();
      bus.resp_v_i = 1'b1; bus.resp_cid_i = 1'b1; bus.resp_ready_i = 2'b10;
      #1;
      n_cmp++; if (bus.resp_yumi_o !== 1'b1 || bus.resp_v_o !== 2'b00 || err !== 1'b0) begin
         n_fail++; $display("FAIL err_resp got y%b v%b e%b exp y1 v00 e0", bus.resp_yumi_o, bus.resp_v_o, err); end
      tick();
      bus.resp_v_i = 1'b0;
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b exp 1", err); end
      tick();
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err); end
   endtask
`endif

   initial begin
      clear_inputs();
      rst = 1'b1;
      for (int c = 0; c < N; c++) m_crd[c] = 0;
      m_ptr = 0; m_ov = 0; m_cid = 0; m_err = 0; m_cmd = '0; m_did = '0;
      #2;
      test_reset();
      test_round_robin();
      test_did_decode();
      test_credit_block();
      test_stall();
      test_same_cycle_credit();
      test_random();
`ifdef BP_IO_CMD_ROUTER_ERR_RESP_EN
      test_err_resp();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
